fetch_ctrl: RTL

Fetch-stage controller that sequences `instr_mem` in the pipelined MIPS core. It owns the fetch PC (`F_valP`) and issues requests to instruction memory over a req/ack handshake that tolerates multi-cycle latency. Returned words go into a 2-entry skid buffer that feeds decode, with backpressure from `D_stall`. It also applies control-flow redirects from execute and squashes in-flight fetches.

---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/fetch_skid.sv | 63 ++++++
 rtl/fetch_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_DRAIN = 2'd2,
    FS_ERR   = 2'd3
  } fs_e;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam int          SKID_DEPTH = 2;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Two-entry FIFO between instruction memory and decode; flush beats push and pop.
module fetch_skid
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [31:0] push_inst_i,
  input  logic [31:0] push_pc_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic [1:0]  cnt_o,
  output logic [31:0] head_inst_o,
  output logic [31:0] head_pc_o
);

  logic [31:0] inst_q [SKID_DEPTH];
  logic [31:0] pc_q   [SKID_DEPTH];
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (push_i) wr_d = ~wr_q;
      if (pop_i)  rd_d = ~rd_q;
      if (push_i && !pop_i)      cnt_d = cnt_q + 2'd1;
      else if (pop_i && !push_i) cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; the top masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      inst_q[wr_q] <= push_inst_i;
      pc_q[wr_q]   <= push_pc_i;
    end
  end

  assign cnt_o       = cnt_q;
  assign head_inst_o = inst_q[rd_q];
  assign head_pc_o   = pc_q[rd_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC, req/ack sequencing, redirect squash, timeout and skid buffer.
// Define FETCH_PERF_EN to build the fetch/stall performance counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req,
  output logic [31:0] F_valP,
  input  logic        im_ack,
  input  logic [31:0] im_inst,
  input  logic        D_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        f_valid,
  output logic [31:0] f_inst,
  output logic [31:0] f_pc,
  output logic        f_err,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  fs_e         state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_q, req_d;
  logic        err_q, err_d;
  logic [WW-1:0] wait_q, wait_d;

  logic        ack_v, tmo, push, pop, flush;
  logic [1:0]  buf_cnt;
  logic [31:0] head_inst, head_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FS_IDLE;
      pc_q     <= word_align(RESET_PC);
      req_pc_q <= word_align(RESET_PC);
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      req_q    <= req_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
    end
  end

  assign ack_v = im_req && im_ack;
  assign tmo   = im_req && !ack_v && (wait_q == WW'(MAX_WAIT - 1));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    req_d    = req_q;
    err_d    = err_q;
    wait_d   = wait_q;
    push     = 1'b0;
    flush    = 1'b0;
    unique case (state_q)
      FS_IDLE: state_d = FS_RUN;
      FS_RUN, FS_DRAIN: begin
        req_d  = im_req && !ack_v;
        // Remember where the request went so a redirect cannot move it.
        if (im_req && !req_q) req_pc_d = pc_q;
        wait_d = (im_req && !ack_v) ? wait_q + WW'(1) : '0;
        if (tmo) begin
          state_d = FS_ERR;
          err_d   = 1'b1;
        end else if (redirect) begin
          pc_d    = word_align(redirect_pc);
          flush   = 1'b1;
          state_d = (im_req && !ack_v) ? FS_DRAIN : FS_RUN;
        end else if (ack_v) begin
          if (state_q == FS_RUN) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
          state_d = FS_RUN;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    im_req = 1'b0;
    unique case (state_q)
      FS_RUN:   im_req = req_q || (buf_cnt < 2'(SKID_DEPTH));
      FS_DRAIN: im_req = 1'b1;
      default:  im_req = 1'b0;
    endcase
  end

  assign F_valP  = req_q ? req_pc_q : pc_q;
  assign f_valid = (buf_cnt != 2'd0);
  assign pop     = f_valid && !D_stall && (state_q != FS_ERR);
  assign f_inst  = f_valid ? head_inst : NOP_INST;
  assign f_pc    = f_valid ? head_pc   : 32'h0;
  assign f_err   = err_q;

  fetch_skid u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_inst_i (im_inst),
    .push_pc_i   (pc_q),
    .pop_i       (pop),
    .flush_i     (flush),
    .cnt_o       (buf_cnt),
    .head_inst_o (head_inst),
    .head_pc_o   (head_pc)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (push)               fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (f_valid && D_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fetch_cnt = 32'd0;
  assign stall_cnt = 32'd0;
`endif

endmodule
